// File: rtl/miv_plic_claim_sequencer_if.sv
// Bus bundle between the PLIC claim sequencer, the MIV_PLIC APB target and the
// interrupt handler: APB initiator signals plus the claimed-ID handshake.
interface miv_plic_claim_sequencer_if #(
    parameter int ID_WIDTH = 5
) ();
    logic [31:0]         INITIATOR_PADDR;
    logic                INITIATOR_PSEL;
    logic                INITIATOR_PENABLE;
    logic                INITIATOR_PWRITE;
    logic [31:0]         INITIATOR_PWDATA;
    logic [31:0]         INITIATOR_PRDATA;
    logic                INITIATOR_PREADY;
    logic                INITIATOR_PSLVERR;
    logic                ID_VALID;
    logic [ID_WIDTH-1:0] CLAIM_ID;
    logic                ID_READY;
    logic                SVC_DONE;

    modport master (
        output INITIATOR_PADDR, INITIATOR_PSEL, INITIATOR_PENABLE, INITIATOR_PWRITE,
        output INITIATOR_PWDATA, ID_VALID, CLAIM_ID,
        input  INITIATOR_PRDATA, INITIATOR_PREADY, INITIATOR_PSLVERR, ID_READY, SVC_DONE
    );

    modport slave (
        input  INITIATOR_PADDR, INITIATOR_PSEL, INITIATOR_PENABLE, INITIATOR_PWRITE,
        input  INITIATOR_PWDATA, ID_VALID, CLAIM_ID,
        output INITIATOR_PRDATA, INITIATOR_PREADY, INITIATOR_PSLVERR, ID_READY, SVC_DONE
    );
endinterface

// File: rtl/miv_plic_claim_sequencer.sv
// APB initiator for MIV_PLIC: keeps the enable register in step with IRQ_EN,
// claims pending sources, hands each ID to the handler and writes the completion.
module miv_plic_claim_sequencer #(
    parameter int          NUM_OF_INTS    = 4,
    parameter int          ID_WIDTH       = 5,
    parameter logic [31:0] ENABLE_ADDR    = 32'h4000_2000,
    parameter logic [31:0] CLAIM_ADDR     = 32'h4020_0004,
    parameter logic [31:0] ENABLE_MASK    = 32'h0000_00FF,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic                          PLIC_IRQ,
    input  logic                          IRQ_EN,
    miv_plic_claim_sequencer_if.master    bus,
    output logic                          BUSY,
    output logic [7:0]                    SPURIOUS_CNT,
    output logic                          APB_ERR
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_WAIT_IRQ      = 3'd0;
    localparam logic [2:0] S_EN_XFER       = 3'd1;
    localparam logic [2:0] S_CLAIM_XFER    = 3'd2;
    localparam logic [2:0] S_DISPATCH      = 3'd3;
    localparam logic [2:0] S_SERVICE       = 3'd4;
    localparam logic [2:0] S_COMPLETE_XFER = 3'd5;

    logic [2:0]          state_q, state_d;
    logic                acc_q, acc_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [31:0]         paddr_q, paddr_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic                en_shadow_q, en_shadow_d;
    logic                en_req_q, en_req_d;
    logic [ID_WIDTH-1:0] claim_id_q, claim_id_d;
    logic [7:0]          spur_q, spur_d;
    logic                err_q, err_d;

    logic                xfer;
    logic [ID_WIDTH-1:0] rd_id;
    logic                id_ok;
    logic                unused_prdata;

    assign xfer  = (state_q == S_EN_XFER) || (state_q == S_CLAIM_XFER) ||
                   (state_q == S_COMPLETE_XFER);
    assign rd_id = bus.INITIATOR_PRDATA[ID_WIDTH-1:0];
    assign id_ok = (rd_id != '0) && (int'(rd_id) <= NUM_OF_INTS);
    assign unused_prdata = ^bus.INITIATOR_PRDATA[31:ID_WIDTH];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tmo_d       = tmo_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        en_shadow_d = en_shadow_q;
        en_req_d    = en_req_q;
        claim_id_d  = claim_id_q;
        spur_d      = spur_q;
        err_d       = err_q;

        case (state_q)
            S_WAIT_IRQ: begin
                // An enable change always wins over a pending claim.
                if (IRQ_EN != en_shadow_q) begin
                    state_d  = S_EN_XFER;
                    en_req_d = IRQ_EN;
                    paddr_d  = ENABLE_ADDR;
                    pwdata_d = IRQ_EN ? ENABLE_MASK : 32'h0;
                end else if (PLIC_IRQ) begin
                    state_d = S_CLAIM_XFER;
                    paddr_d = CLAIM_ADDR;
                end
            end
            S_DISPATCH: begin
                if (bus.ID_READY) state_d = S_SERVICE;
            end
            S_SERVICE: begin
                if (bus.SVC_DONE) begin
                    state_d  = S_COMPLETE_XFER;
                    paddr_d  = CLAIM_ADDR;
                    pwdata_d = 32'(claim_id_q);
                end
            end
            default: ;
        endcase

        // Shared setup/access sequencing for the three APB transfer states.
        if (xfer) begin
            if (!acc_q) begin
                acc_d = 1'b1;
                tmo_d = '0;
            end else if (bus.INITIATOR_PREADY) begin
                acc_d = 1'b0;
                if (bus.INITIATOR_PSLVERR) err_d = 1'b1;
                case (state_q)
                    S_EN_XFER: begin
                        en_shadow_d = en_req_q;
                        state_d     = S_WAIT_IRQ;
                    end
                    S_CLAIM_XFER: begin
                        if (bus.INITIATOR_PSLVERR || !id_ok) begin
                            spur_d  = (spur_q == 8'hFF) ? spur_q : spur_q + 8'd1;
                            state_d = S_WAIT_IRQ;
                        end else begin
                            claim_id_d = rd_id;
                            state_d    = S_DISPATCH;
                        end
                    end
                    default: state_d = S_WAIT_IRQ;
                endcase
            end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
                // Abandon the transfer; en_shadow is untouched so an enable retries.
                acc_d   = 1'b0;
                err_d   = 1'b1;
                state_d = S_WAIT_IRQ;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_WAIT_IRQ;
            acc_q       <= 1'b0;
            tmo_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            en_shadow_q <= 1'b0;
            en_req_q    <= 1'b0;
            claim_id_q  <= '0;
            spur_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tmo_q       <= tmo_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            en_shadow_q <= en_shadow_d;
            en_req_q    <= en_req_d;
            claim_id_q  <= claim_id_d;
            spur_q      <= spur_d;
            err_q       <= err_d;
        end
    end

    assign bus.INITIATOR_PSEL    = xfer;
    assign bus.INITIATOR_PENABLE = xfer & acc_q;
    assign bus.INITIATOR_PWRITE  = (state_q == S_EN_XFER) || (state_q == S_COMPLETE_XFER);
    assign bus.INITIATOR_PADDR   = paddr_q;
    assign bus.INITIATOR_PWDATA  = pwdata_q;
    assign bus.ID_VALID          = (state_q == S_DISPATCH);
    assign bus.CLAIM_ID          = claim_id_q;
    assign BUSY                  = (state_q != S_WAIT_IRQ);
    assign SPURIOUS_CNT          = spur_q;
    assign APB_ERR               = err_q;
endmodule

// File: tb/tb_miv_plic_claim_sequencer.sv
// Directed + randomized bench: a small PLIC/handler model drives the sequencer and
// logs bus events, which are compared against the expected claim/complete order.
module tb_miv_plic_claim_sequencer;
    localparam int          NI = 4;
    localparam int          IW = 5;
    localparam logic [31:0] EA = 32'h4000_2000;
    localparam logic [31:0] CA = 32'h4020_0004;
    localparam logic [31:0] EM = 32'h0000_00FF;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       PLIC_IRQ;
    logic       IRQ_EN;
    logic       BUSY;
    logic [7:0] SPURIOUS_CNT;
    logic       APB_ERR;

    miv_plic_claim_sequencer_if #(.ID_WIDTH(IW)) bus ();

    miv_plic_claim_sequencer #(
        .NUM_OF_INTS(NI), .ID_WIDTH(IW), .ENABLE_ADDR(EA), .CLAIM_ADDR(CA),
        .ENABLE_MASK(EM), .TIMEOUT_CYCLES(255)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PLIC_IRQ(PLIC_IRQ), .IRQ_EN(IRQ_EN),
        .bus(bus), .BUSY(BUSY), .SPURIOUS_CNT(SPURIOUS_CNT), .APB_ERR(APB_ERR)
    );

    always #5 PCLK = ~PCLK;

    // model state
    int          tests = 0;
    int          fails = 0;
    logic [31:0] en_reg;
    logic [NI:1] pend;
    int          spur_left, pslv_left, spur_any;
    int          pready_mode, rdy_mode;
    bit          svc_hold, svc_pend;
    int          svc_cnt;
    int          ev[$];
    int          exp_ev[$];
    logic        s_vld, s_busy, s_psel, s_pen;
    logic [IW-1:0] s_id;
    logic [64:0] setup_sig;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag);
        chk({tag, "_count"}, 64'(ev.size()), 64'(exp_ev.size()));
        for (int i = 0; i < exp_ev.size() && i < ev.size(); i++)
            chk($sformatf("%s_ev%0d", tag, i), 64'(ev[i]), 64'(exp_ev[i]));
        ev.delete();
        exp_ev.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_paddr"},  64'(bus.INITIATOR_PADDR), 64'(0));
        chk({tag, "_pwdata"}, 64'(bus.INITIATOR_PWDATA), 64'(0));
        chk({tag, "_ctl"}, 64'({bus.INITIATOR_PSEL, bus.INITIATOR_PENABLE, bus.INITIATOR_PWRITE,
                                bus.ID_VALID, BUSY, APB_ERR}), 64'(0));
        chk({tag, "_claim_id"}, 64'(bus.CLAIM_ID), 64'(0));
        chk({tag, "_spur"}, 64'(SPURIOUS_CNT), 64'(0));
    endtask

    function automatic int lowest(input logic [NI:1] p, input logic [31:0] en);
        for (int i = 1; i <= NI; i++) if (p[i] && en[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        en_reg = '0; pend = '0; spur_left = 0; pslv_left = 0;
        svc_pend = 0; svc_hold = 0; svc_cnt = 0;
        ev.delete(); exp_ev.delete();
    endtask

    // One clock: drive inputs at negedge, sample outputs, apply bus side effects after posedge.
    task automatic tick();
        logic        done, dwr;
        logic [31:0] daddr, ddata, r;
        int          pick;
        @(negedge PCLK);
        PLIC_IRQ = (spur_left > 0) || (pslv_left > 0) || (lowest(pend, en_reg) != 0);
        case (pready_mode)
            0:       bus.INITIATOR_PREADY = 1'b1;
            1:       bus.INITIATOR_PREADY = 1'($urandom_range(0, 1));
            default: bus.INITIATOR_PREADY = 1'b0;
        endcase
        r = $urandom;
        bus.INITIATOR_PSLVERR = (pready_mode == 1 && !bus.INITIATOR_PREADY) ? r[0] : 1'b0;
        if (spur_left > 0) begin
            pick = (spur_any != 0 && r[1:0] != 2'b00) ? $urandom_range(5, 31) : 0;
            bus.INITIATOR_PRDATA = {r[31:5], 5'(pick)};
        end else if (pslv_left > 0) begin
            bus.INITIATOR_PRDATA  = 32'd2;
            bus.INITIATOR_PSLVERR = 1'b1;
        end else begin
            bus.INITIATOR_PRDATA = {r[31:5], 5'(lowest(pend, en_reg))};
        end
        if (svc_pend && !svc_hold && svc_cnt == 0) begin
            bus.SVC_DONE = 1'b1;
            svc_pend = 0;
        end else begin
            bus.SVC_DONE = (!svc_pend && rdy_mode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (svc_pend && svc_cnt > 0) svc_cnt--;
        end
        bus.ID_READY = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;

        s_vld  = bus.ID_VALID;
        s_id   = bus.CLAIM_ID;
        s_busy = BUSY;
        s_psel = bus.INITIATOR_PSEL;
        s_pen  = bus.INITIATOR_PENABLE;
        if (s_vld && bus.ID_READY) begin
            ev.push_back(int'(s_id));
            svc_pend = 1;
            svc_cnt  = $urandom_range(0, 3);
        end
        if (s_psel && !s_pen)
            setup_sig = {bus.INITIATOR_PWRITE, bus.INITIATOR_PADDR, bus.INITIATOR_PWDATA};
        if (s_psel && s_pen)
            chk("apb_hold", 64'({bus.INITIATOR_PWRITE, bus.INITIATOR_PADDR, bus.INITIATOR_PWDATA} ^ setup_sig), 64'(0));
        done  = s_psel && s_pen && bus.INITIATOR_PREADY;
        dwr   = bus.INITIATOR_PWRITE;
        daddr = bus.INITIATOR_PADDR;
        ddata = bus.INITIATOR_PWDATA;
        @(posedge PCLK);
        #1;
        if (done) begin
            if (dwr && daddr == EA) begin
                en_reg = ddata;
                ev.push_back(ddata == EM ? 301 : ddata == 0 ? 300 : 309);
            end else if (dwr && daddr == CA) begin
                ev.push_back(100 + int'(ddata));
            end else if (!dwr && daddr == CA) begin
                if (spur_left > 0) begin
                    spur_left--; ev.push_back(200);
                end else if (pslv_left > 0) begin
                    pslv_left--; ev.push_back(250);
                end else begin
                    pick = lowest(pend, en_reg);
                    if (pick != 0) pend[pick] = 1'b0;
                    ev.push_back(200 + pick);
                end
            end else begin
                ev.push_back(999);
            end
        end
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < max) begin
            tick();
            n++;
            if (!s_busy && !PLIC_IRQ && !svc_pend && (IRQ_EN == (en_reg != 0))) quiet++;
            else quiet = 0;
        end
        chk({tag, "_idle"}, 64'(quiet >= 3), 64'(1));
    endtask

    initial begin
        int n, acc, m, s, exp_spur;
        model_reset();
        pready_mode = 0; rdy_mode = 0; spur_any = 0;
        PRESET = 1'b1; IRQ_EN = 1'b0; PLIC_IRQ = 1'b0;
        bus.INITIATOR_PRDATA = '0; bus.INITIATOR_PREADY = 1'b1; bus.INITIATOR_PSLVERR = 1'b0;
        bus.ID_READY = 1'b0; bus.SVC_DONE = 1'b0;
        setup_sig = '0;
        repeat (2) @(negedge PCLK);
        chk_zero("reset");
        PRESET = 1'b0;

        // T1: enable write only, no claim
        IRQ_EN = 1'b1;
        wait_idle(50, "t1");
        exp_ev = '{301};
        chk_ev("t1");
        chk("t1_busy", 64'(s_busy), 64'(0));

        // T2: single source, 3-cycle latency to ID_VALID
        pend[1] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!s_vld && n < 20);
        chk("t2_latency", 64'(n - 1), 64'(3));
        chk("t2_id", 64'(s_id), 64'(1));
        wait_idle(50, "t2");
        exp_ev = '{201, 1, 101};
        chk_ev("t2");

        // T3: two pending sources, random wait states and handler timing
        pready_mode = 1; rdy_mode = 1;
        pend[2] = 1'b1; pend[3] = 1'b1;
        wait_idle(200, "t3");
        exp_ev = '{202, 2, 102, 203, 3, 103};
        chk_ev("t3");

        // T4: disable requested during SERVICE is deferred until after completion
        pready_mode = 0; rdy_mode = 0; svc_hold = 1;
        pend[1] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!svc_pend && n < 50);
        IRQ_EN = 1'b0;
        repeat (10) tick();
        exp_ev = '{201, 1};
        chk_ev("t4_held");
        svc_hold = 0;
        wait_idle(50, "t4");
        exp_ev = '{101, 300};
        chk_ev("t4_done");
        pend[1] = 1'b1;
        repeat (20) tick();
        chk("t4_noclaim_ev", 64'(ev.size()), 64'(0));
        chk("t4_noclaim_busy", 64'(s_busy), 64'(0));
        pend = '0;
        IRQ_EN = 1'b1;
        wait_idle(50, "t4_reen");
        exp_ev = '{301};
        chk_ev("t4_reen");

        // T5: three zero-ID claims
        spur_left = 3;
        wait_idle(100, "t5");
        exp_ev = '{200, 200, 200};
        chk_ev("t5");
        chk("t5_spur", 64'(SPURIOUS_CNT), 64'(3));
        exp_spur = 3;

        // Randomized rounds: random pending mask plus random spurious/out-of-range reads
        pready_mode = 1; rdy_mode = 1; spur_any = 1;
        for (int k = 0; k < 8; k++) begin
            m = $urandom_range(1, 15);
            s = $urandom_range(0, 2);
            spur_left = s;
            pend = 4'(m);
            for (int j = 0; j < s; j++) exp_ev.push_back(200);
            for (int i = 1; i <= NI; i++)
                if (m[i-1]) begin
                    exp_ev.push_back(200 + i); exp_ev.push_back(i); exp_ev.push_back(100 + i);
                end
            exp_spur += s;
            wait_idle(600, $sformatf("rnd%0d", k));
            chk_ev($sformatf("rnd%0d", k));
            chk($sformatf("rnd%0d_spur", k), 64'(SPURIOUS_CNT), 64'(exp_spur));
        end
        chk("rnd_no_err", 64'(APB_ERR), 64'(0));

        // PSLVERR on a claim: sticky error, data treated as spurious
        pready_mode = 0; rdy_mode = 0;
        pslv_left = 1;
        wait_idle(50, "slverr");
        exp_ev = '{250};
        chk_ev("slverr");
        chk("slverr_err", 64'(APB_ERR), 64'(1));
        chk("slverr_spur", 64'(SPURIOUS_CNT), 64'(exp_spur + 1));

        // Reset asserted mid-DISPATCH clears outputs immediately
        rdy_mode = 2;
        pend[2] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!s_vld && n < 50);
        chk("mid_dispatch_vld", 64'(s_vld), 64'(1));
        #2 PRESET = 1'b1;
        #1 chk_zero("mid_reset");
        model_reset();
        @(negedge PCLK);
        PRESET = 1'b0;
        rdy_mode = 0;
        wait_idle(50, "post_reset");
        exp_ev = '{301};
        chk_ev("post_reset");

        // Timeout: PREADY held low during a claim
        pready_mode = 2;
        pend[1] = 1'b1;
        acc = 0; n = 0;
        while (n < 400) begin
            tick(); n++;
            if (s_psel && s_pen) acc++;
            else if (acc > 0 && !s_psel) break;
        end
        chk("tmo_access_cycles", 64'(acc), 64'(256));
        chk("tmo_psel", 64'(s_psel), 64'(0));
        chk("tmo_busy", 64'(s_busy), 64'(0));
        chk("tmo_err", 64'(APB_ERR), 64'(1));
        pend = '0;
        pready_mode = 0;
        wait_idle(50, "tmo");
        exp_ev = '{200};
        chk_ev("tmo");
        chk("tmo_spur", 64'(SPURIOUS_CNT), 64'(1));

        // Spurious counter saturation
        spur_any = 1;
        spur_left = 300;
        wait_idle(3000, "sat");
        chk("sat_reads", 64'(ev.size()), 64'(300));
        ev.delete();
        chk("sat_spur", 64'(SPURIOUS_CNT), 64'(255));

        // Normal loop still works; CLAIM_ID holds afterwards, error stays sticky
        pready_mode = 1; rdy_mode = 1;
        pend[4] = 1'b1;
        wait_idle(200, "final");
        exp_ev = '{204, 4, 104};
        chk_ev("final");
        chk("final_claim_id", 64'(bus.CLAIM_ID), 64'(4));
        chk("final_err_sticky", 64'(APB_ERR), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
